poly_ram_unload: RTL and testbench
==================================

# poly_ram_unload

Streams one 512-coefficient polynomial out of the poly RAM as a valid/ready coefficient stream. It is the read-side counterpart of the in-place RAM arithmetic blocks (add/subtract/multiply) that write results back into the same poly RAM. Each coefficient passes through a single conditional subtraction by Q on the way out, so the stream carries fully reduced values. A 2-entry output FIFO absorbs the RAM read latency and downstream backpressure without losing throughput.

## Interface
Parameters:
- N_COEFF, 512: coefficients per polynomial
- ADDR_W, 9: poly RAM address width
- COEFF_W, 16: coefficient / RAM data width
- Q, 12289: modulus used by the output freeze

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin unload; sampled only in IDLE
- ram_en  out  1  RAM read enable
- ram_addr  out  ADDR_W  RAM read address
- ram_dout  in  COEFF_W  RAM read data, valid exactly 1 cycle after a ram_en cycle
- m_data  out  COEFF_W  output coefficient, in [0, Q)
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts; a beat transfers when m_valid and m_ready are both high
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse after the final beat transfers

## Operation
- FSM states:
  - IDLE: no reads issued. start=1 → RUN, with addr counter cleared to 0.
  - RUN: issue reads at addr 0..N_COEFF-1 in order. After the read at N_COEFF-1 is issued → DRAIN.
  - DRAIN: no reads issued. When there is no in-flight read, the FIFO is empty, and the last beat transfers → IDLE.
- Read issue rule:
  - ram_en = (state==RUN) && (fifo_count + inflight − pop < 2), where pop = m_valid && m_ready.
  - The counter increments on each issued read; ram_addr = counter.
  - ram_addr holds its value when ram_en is low.
- inflight:
  - Set in the cycle after ram_en=1, cleared otherwise.
  - The returning word is frozen and pushed into the FIFO at the end of that cycle.
- Freeze: out = (ram_dout ≥ Q) ? ram_dout − Q : ram_dout. The input is guaranteed < 2Q; the unsigned compare is done at COEFF_W bits.
- FIFO behaviour:
  - Depth 2, first-word-fall-through; m_valid = fifo not empty.
  - Push and pop in the same cycle leaves the count unchanged.
  - The FIFO never overflows, because of the read issue rule.
- AXI-style rules:
  - m_data and m_valid are stable while m_valid && !m_ready.
  - m_valid does not depend combinationally on m_ready.
- start while busy: ignored.
- Beat count per run is exactly N_COEFF, emitted in address order.

## Timing
- Reset values: ram_en=0, ram_addr=0, m_valid=0, m_data=0, busy=0, done=0, state=IDLE, FIFO empty, inflight=0.
- Reset mid-run: everything returns to the reset values immediately (asynchronously). In-flight data is discarded. No done pulse.
- Start latency, with start high in cycle 0:
  - busy and ram_en (addr 0) are high in cycle 1.
  - First m_valid is in cycle 3.
- Throughput with m_ready held high: 1 beat per cycle. Beat k is valid in cycle 3+k; the last beat (511) is in cycle 514.
- done is high for exactly cycle (last transfer cycle + 1). busy is low in that same cycle, and a new start is accepted in it.
- Backpressure:
  - With m_ready low, reads stall once fifo_count + inflight reaches 2.
  - At most 2 words are held.
  - Resuming m_ready restores 1 beat/cycle after 1 cycle.
- Boundary values:
  - ram_dout = Q−1 → Q−1.
  - ram_dout = Q → 0.
  - ram_dout = 2Q−1 → Q−1.

## Structure
- Shared package newhope_pkg holds N_COEFF, ADDR_W, COEFF_W, Q and the state enum (IDLE/RUN/DRAIN); the other poly RAM blocks also use these constants.
- Sub-module coeff_freeze is combinational (COEFF_W in/out, Q parameter) and is reusable by the arithmetic blocks.
- The FIFO is inline: 2 registers plus a count.

## Test plan
- Basic run: RAM[i] = i, m_ready=1, start pulse → 512 beats with values 0..511 in cycles 3..514, done in cycle 515, busy low in 515.
- Freeze: RAM[0]=12288, RAM[1]=12289, RAM[2]=24577, RAM[3]=0 → first beats 12288, 0, 12288, 0.
- Backpressure: m_ready random 50% plus a 20-cycle hold-low → no lost, duplicated or reordered beat. m_data is stable while stalled, and ram_en is never high while fifo_count+inflight=2.
- Start while busy: second start pulse at cycle 100 → ignored. Exactly 512 beats, one done pulse. Back-to-back start in the done cycle → second run begins.
- Async reset: assert rst at cycle 200 between edges → outputs are at their reset values before the next edge, and a subsequent start emits the full 512 beats from addr 0.

Source files
------------

// File: rtl/newhope_pkg.sv
// Constants and state encoding shared by the poly RAM blocks
// (unload, add, subtract, multiply).
package newhope_pkg;

  localparam int N_COEFF = 512;
  localparam int ADDR_W  = 9;
  localparam int COEFF_W = 16;
  localparam int Q       = 12289;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/poly_ram_unload_if.sv
// Poly RAM read port plus the outgoing valid/ready coefficient stream.
// master = unload engine side, slave = RAM / downstream consumer side.
interface poly_ram_unload_if #(
  parameter int ADDR_W  = newhope_pkg::ADDR_W,
  parameter int COEFF_W = newhope_pkg::COEFF_W
);

  logic               ram_en;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COEFF_W-1:0] ram_dout;
  logic [COEFF_W-1:0] m_data;
  logic               m_valid;
  logic               m_ready;

  modport master (
    output ram_en, ram_addr, m_data, m_valid,
    input  ram_dout, m_ready
  );

  modport slave (
    input  ram_en, ram_addr, m_data, m_valid,
    output ram_dout, m_ready
  );

endinterface

// File: rtl/coeff_freeze.sv
// Single conditional subtraction by Q; input is assumed to lie in [0, 2Q).
module coeff_freeze #(
  parameter int COEFF_W = newhope_pkg::COEFF_W,
  parameter int Q       = newhope_pkg::Q
) (
  input  logic [COEFF_W-1:0] din,
  output logic [COEFF_W-1:0] dout
);

  localparam logic [COEFF_W-1:0] Q_C = COEFF_W'(Q);

  assign dout = (din >= Q_C) ? (din - Q_C) : din;

endmodule

// File: rtl/poly_ram_unload.sv
// Streams one polynomial out of the poly RAM through the freeze stage
// and a 2-entry first-word-fall-through FIFO.
//
// state | meaning
// IDLE  | no reads; start clears the address counter and enters RUN
// RUN   | one read per cycle while the FIFO has room, addr 0..N_COEFF-1
// DRAIN | all reads issued; wait for the last beat to leave
module poly_ram_unload
  import newhope_pkg::*;
#(
  parameter int N_COEFF = newhope_pkg::N_COEFF,
  parameter int ADDR_W  = newhope_pkg::ADDR_W,
  parameter int COEFF_W = newhope_pkg::COEFF_W,
  parameter int Q       = newhope_pkg::Q
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  poly_ram_unload_if.master     bus,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_COEFF - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               inflight_q;
  logic [COEFF_W-1:0] fifo0_q, fifo1_q;
  logic [1:0]         count_q;
  logic               done_q;

  logic               pop;
  logic               issue;
  logic               finish;
  logic [2:0]         level;
  logic [COEFF_W-1:0] frozen;

  coeff_freeze #(
    .COEFF_W (COEFF_W),
    .Q       (Q)
  ) u_freeze (
    .din  (bus.ram_dout),
    .dout (frozen)
  );

  // Words already committed: held in the FIFO or returning from the RAM.
  assign level = {1'b0, count_q} + {2'b00, inflight_q};
  assign pop   = (count_q != 2'd0) && bus.m_ready;
  assign issue = (state_q == RUN) && ((level - {2'b00, pop}) < 3'd2);

  assign bus.ram_en   = issue;
  assign bus.ram_addr = addr_q;
  assign bus.m_valid  = (count_q != 2'd0);
  assign bus.m_data   = fifo0_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && (addr_q == LAST_ADDR)) state_d = DRAIN;
      DRAIN: begin
        if (!inflight_q && (count_q == 2'd1) && pop) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      done_q     <= finish;
      if ((state_q == IDLE) && start) addr_q <= '0;
      else if (issue)                 addr_q <= addr_q + 1'b1;
    end
  end

  // fifo0_q is always the head; a push lands behind whatever survives the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0_q <= '0;
      fifo1_q <= '0;
      count_q <= 2'd0;
    end else begin
      case ({inflight_q, pop})
        2'b01: begin
          fifo0_q <= fifo1_q;
          count_q <= count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) fifo0_q <= frozen;
          else                 fifo1_q <= frozen;
          count_q <= count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            fifo0_q <= frozen;
          end else begin
            fifo0_q <= fifo1_q;
            fifo1_q <= frozen;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_ram_unload.sv
// Self-checking bench for poly_ram_unload: RAM model, reference queue of
// reduced coefficients, timing/backpressure/reset scenarios.
module tb_poly_ram_unload;
  import newhope_pkg::*;

  logic clk = 1'b0;
  logic rst, start, busy, done;

  poly_ram_unload_if bus ();

  poly_ram_unload dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus.master),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  logic [COEFF_W-1:0] ram [N_COEFF];
  int                 expv [N_COEFF];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t0 = 0, mode = 0;
  int beat_idx, issue_idx, done_cnt, first_v, last_x, done_c, busy_at_done, busy1, en1;
  logic               prev_stall = 1'b0;
  logic [COEFF_W-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc - t0);
    end
  endtask

  always @(posedge clk) cyc++;

  // Synchronous-read RAM: data one cycle after an enable.
  always @(posedge clk) if (bus.ram_en) bus.ram_dout <= ram[bus.ram_addr];

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1)
        bus.m_ready = ((cyc - t0) >= 60 && (cyc - t0) < 80) ? 1'b0 : 1'($urandom % 2);
      else
        bus.m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (cyc - t0 == 1) begin
        busy1 = int'(busy);
        en1   = int'(bus.ram_en);
      end
      if (prev_stall) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_data", bus.m_data, prev_data);
      end
      if (bus.ram_en) begin
        check("issue_room",
              ((issue_idx - beat_idx - ((bus.m_valid && bus.m_ready) ? 1 : 0)) < 2) ? 1 : 0, 1);
        check("addr", bus.ram_addr, issue_idx);
        issue_idx++;
      end
      if (bus.m_valid && first_v < 0) first_v = cyc - t0;
      if (bus.m_valid && bus.m_ready) begin
        if (beat_idx < N_COEFF) check("beat", bus.m_data, expv[beat_idx]);
        else                    check("extra_beat", beat_idx, N_COEFF - 1);
        beat_idx++;
        last_x = cyc - t0;
      end
      if (done) begin
        done_cnt++;
        done_c       = cyc - t0;
        busy_at_done = int'(busy);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic run_init();
    beat_idx = 0; issue_idx = 0; done_cnt = 0;
    first_v = -1; last_x = -1; done_c = -1; busy_at_done = -1;
    busy1 = 0; en1 = 0;
    for (int i = 0; i < N_COEFF; i++) expv[i] = int'(ram[i]) % Q;
  endtask

  task automatic fill_ram(input bit rnd);
    for (int i = 0; i < N_COEFF; i++)
      ram[i] = rnd ? COEFF_W'($urandom_range(0, 2 * Q - 1)) : COEFF_W'(i);
  endtask

  task automatic start_run();
    @(posedge clk);
    #1;
    run_init();
    t0    = cyc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", (done_cnt > 0) ? 1 : 0, 1);
  endtask

  task automatic wait_rel(input int c);
    int n = 0;
    while ((cyc - t0) < c && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fill_ram(0);
    run_init();
    repeat (3) @(posedge clk);
    #2;
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;

    // Basic run with identity RAM contents and exact cycle timing.
    start_run();
    wait_done(1000);
    check("t1_busy_c1", busy1, 1);
    check("t1_en_c1", en1, 1);
    check("t1_first_valid", first_v, 3);
    check("t1_last_beat", last_x, 514);
    check("t1_done_cycle", done_c, 515);
    check("t1_busy_at_done", busy_at_done, 0);
    check("t1_beats", beat_idx, N_COEFF);
    repeat (3) @(negedge clk);
    check("t1_done_pulses", done_cnt, 1);

    // Freeze boundaries at the front of random data.
    fill_ram(1);
    ram[0] = COEFF_W'(Q - 1);
    ram[1] = COEFF_W'(Q);
    ram[2] = COEFF_W'(2 * Q - 1);
    ram[3] = '0;
    start_run();
    check("t2_exp0", expv[0], Q - 1);
    check("t2_exp1", expv[1], 0);
    check("t2_exp2", expv[2], Q - 1);
    wait_done(1000);
    check("t2_beats", beat_idx, N_COEFF);

    // Random backpressure with a long hold-low window.
    mode = 1;
    fill_ram(1);
    start_run();
    wait_done(5000);
    repeat (3) @(negedge clk);
    check("t3_beats", beat_idx, N_COEFF);
    check("t3_done_pulses", done_cnt, 1);
    mode = 0;

    // Start while busy is ignored; start in the done cycle is accepted.
    fill_ram(1);
    start_run();
    wait_rel(100);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1000);
    check("t4_beats", beat_idx, N_COEFF);
    check("t4_done_pulses", done_cnt, 1);
    check("t4_done_cycle", done_c, 515);
    start = 1'b1;
    run_init();
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1000);
    check("t4b_beats", beat_idx, N_COEFF);
    check("t4b_done_cycle", done_c, 515);
    repeat (3) @(negedge clk);
    check("t4b_done_pulses", done_cnt, 1);

    // Asynchronous reset mid-run, then a clean full run.
    fill_ram(1);
    start_run();
    wait_rel(200);
    #1;
    rst = 1'b1;
    #1;
    check("t5_ram_en", bus.ram_en, 0);
    check("t5_ram_addr", bus.ram_addr, 0);
    check("t5_m_valid", bus.m_valid, 0);
    check("t5_m_data", bus.m_data, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_beats_before", beat_idx, 197);
    check("t5_no_done", done_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start_run();
    wait_done(1000);
    check("t5_beats", beat_idx, N_COEFF);
    check("t5_done_cycle", done_c, 515);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
